// File: rtl/uart_text_buffer_if.sv
// ============================================================================
//  Module      : uart_text_buffer_if
//  Description : Byte-stream handshake between the uart core and the text
//                buffer: received-byte strobe plus transmit request/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_text_buffer_if #(
    parameter int CHAR_WIDTH = 8
);
    logic                  rx_valid;
    logic [CHAR_WIDTH-1:0] rx_data;
    logic                  tx_ready;
    logic                  tx_send;
    logic [CHAR_WIDTH-1:0] tx_data;

    // uart side: produces received bytes and transmitter status
    modport master (
        output rx_valid, rx_data, tx_ready,
        input  tx_send, tx_data
    );

    // text buffer side
    modport slave (
        input  rx_valid, rx_data, tx_ready,
        output tx_send, tx_data
    );
endinterface

`default_nettype wire

// File: rtl/uart_text_buffer.sv
// ============================================================================
//  Module      : uart_text_buffer
//  Description : Line-editing text buffer. Received bytes are appended to a
//                flat character vector (BS/DEL delete, CR clears), edits are
//                echoed through a TX FIFO, and a button edge queues the
//                switch value as uppercase hex.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_text_buffer #(
    parameter int NUM_CHARS  = 60,
    parameter int CHAR_WIDTH = 8,
    parameter int SW_WIDTH   = 8,
    parameter int TX_DEPTH   = 8,
    parameter bit ECHO_EN    = 1'b1
) (
    input  wire logic                             clk,
    input  wire logic                             reset,
    uart_text_buffer_if.slave                     bus,
    input  wire logic                             btn,
    input  wire logic [SW_WIDTH-1:0]              sw,
    output logic      [NUM_CHARS*CHAR_WIDTH-1:0]  characters,
    output logic      [$clog2(NUM_CHARS+1)-1:0]   char_count,
    output logic                                  overflow,
    output logic                                  tx_drop
);
    localparam int ND   = (SW_WIDTH + 3) / 4;
    localparam int GMAX = (ND > 3) ? ND : 3;
    localparam int LW   = $clog2(GMAX + 1);
    localparam int AW   = $clog2(TX_DEPTH);
    localparam int PW   = AW + 1;
    localparam int CW   = $clog2(NUM_CHARS + 1);
    localparam int VW   = NUM_CHARS * CHAR_WIDTH;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT_LO = 2'd1;
    localparam logic [1:0] S_WAIT_HI = 2'd2;

    localparam logic [CW-1:0] FULL_COUNT = CW'(NUM_CHARS);
    localparam logic [PW-1:0] DEPTH      = PW'(TX_DEPTH);

    // RX decode and the echo group it produces (rx_len == 0: no group)
    logic                  is_print, is_del, is_cr;
    logic [CHAR_WIDTH-1:0] rx_grp [GMAX];
    logic [LW-1:0]         rx_len;
    logic [CHAR_WIDTH-1:0] btn_grp [GMAX];
    logic [4*ND-1:0]       sw_ext;
    logic [3:0]            nib;
    logic                  btn_prev, btn_pend, btn_edge;

    // FIFO
    logic [CHAR_WIDTH-1:0] fifo_mem [TX_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr, used, free;
    logic                  empty, full, push, pop;

    // group sequencer and one-deep echo pending slot
    logic                  seq_active;
    logic [LW-1:0]         seq_len, seq_idx;
    logic [CHAR_WIDTH-1:0] seq_buf [GMAX];
    logic                  echo_pend;
    logic [LW-1:0]         echo_len;
    logic [CHAR_WIDTH-1:0] echo_buf [GMAX];

    // arbitration results
    logic                  acc_valid, acc_fits, admit;
    logic [LW-1:0]         acc_len;
    logic [CHAR_WIDTH-1:0] acc_grp [GMAX];
    logic                  take_echo, set_echo, take_btn, set_btn, drop_echo;

    logic [1:0]            state;

    assign is_print = bus.rx_valid && (bus.rx_data >= CHAR_WIDTH'(8'h20))
                                   && (bus.rx_data <= CHAR_WIDTH'(8'h7E));
    assign is_del   = bus.rx_valid && ((bus.rx_data == CHAR_WIDTH'(8'h08)) ||
                                       (bus.rx_data == CHAR_WIDTH'(8'h7F)));
    assign is_cr    = bus.rx_valid && (bus.rx_data == CHAR_WIDTH'(8'h0D));
    assign btn_edge = btn && !btn_prev;
    assign sw_ext   = (4*ND)'(sw);

    assign used  = wr_ptr - rd_ptr;
    assign free  = DEPTH - used;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = seq_active && !full;
    assign pop   = (state == S_IDLE) && !empty && bus.tx_ready;

    // Echo group for the byte arriving this cycle (a delete on an empty buffer echoes nothing)
    always_comb begin
        for (int i = 0; i < GMAX; i++) rx_grp[i] = '0;
        rx_len = '0;
        if (ECHO_EN) begin
            if (is_print) begin
                rx_grp[0] = bus.rx_data;
                rx_len    = LW'(1);
            end else if (is_del && (char_count != '0)) begin
                rx_grp[0] = CHAR_WIDTH'(8'h08);
                rx_grp[1] = CHAR_WIDTH'(8'h20);
                rx_grp[2] = CHAR_WIDTH'(8'h08);
                rx_len    = LW'(3);
            end else if (is_cr) begin
                rx_grp[0] = CHAR_WIDTH'(8'h0D);
                rx_grp[1] = CHAR_WIDTH'(8'h0A);
                rx_len    = LW'(2);
            end
        end
    end

    // Switch value as uppercase hex digits, most significant nibble first
    always_comb begin
        nib = '0;
        for (int i = 0; i < GMAX; i++) btn_grp[i] = '0;
        for (int i = 0; i < ND; i++) begin
            nib        = sw_ext[4*(ND-1-i) +: 4];
            btn_grp[i] = CHAR_WIDTH'(nib) +
                         ((nib < 4'd10) ? CHAR_WIDTH'(8'h30) : CHAR_WIDTH'(8'h37));
        end
    end

    // Pick at most one group per cycle for the idle sequencer; echoes outrank the button
    always_comb begin
        acc_valid = 1'b0;
        acc_len   = '0;
        for (int i = 0; i < GMAX; i++) acc_grp[i] = '0;
        take_echo = 1'b0;
        set_echo  = 1'b0;
        take_btn  = 1'b0;
        set_btn   = 1'b0;
        drop_echo = 1'b0;
        if (!seq_active) begin
            if (echo_pend) begin
                acc_valid = 1'b1;
                acc_len   = echo_len;
                for (int i = 0; i < GMAX; i++) acc_grp[i] = echo_buf[i];
                take_echo = 1'b1;
                set_echo  = (rx_len != '0);
            end else if (rx_len != '0) begin
                acc_valid = 1'b1;
                acc_len   = rx_len;
                for (int i = 0; i < GMAX; i++) acc_grp[i] = rx_grp[i];
            end else if (btn_pend) begin
                acc_valid = 1'b1;
                acc_len   = LW'(ND);
                for (int i = 0; i < GMAX; i++) acc_grp[i] = btn_grp[i];
                take_btn  = 1'b1;
            end else if (btn_edge && !bus.rx_valid) begin
                acc_valid = 1'b1;
                acc_len   = LW'(ND);
                for (int i = 0; i < GMAX; i++) acc_grp[i] = btn_grp[i];
            end
        end else if (rx_len != '0) begin
            drop_echo = echo_pend;
            set_echo  = !echo_pend;
        end
        // a button edge that could not be taken directly waits in the single pending slot
        if (btn_edge && !btn_pend && !(acc_valid && !take_echo && rx_len == '0))
            set_btn = 1'b1;
    end

    assign acc_fits = ((PW+LW)'(free) >= (PW+LW)'(acc_len));
    assign admit    = acc_valid && acc_fits;

    // Character vector, count and sticky overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            characters <= '0;
            char_count <= '0;
            overflow   <= 1'b0;
        end else if (is_print) begin
            characters <= {characters[VW-CHAR_WIDTH-1:0], bus.rx_data};
            if (char_count == FULL_COUNT) overflow   <= 1'b1;
            else                          char_count <= char_count + CW'(1);
        end else if (is_del && (char_count != '0)) begin
            characters <= {{CHAR_WIDTH{1'b0}}, characters[VW-1:CHAR_WIDTH]};
            char_count <= char_count - CW'(1);
        end else if (is_cr) begin
            characters <= '0;
            char_count <= '0;
        end
    end

    // Sequencer, pending slots, button history, write pointer and drop pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seq_active <= 1'b0;
            seq_len    <= '0;
            seq_idx    <= '0;
            for (int i = 0; i < GMAX; i++) seq_buf[i] <= '0;
            echo_pend  <= 1'b0;
            echo_len   <= '0;
            for (int i = 0; i < GMAX; i++) echo_buf[i] <= '0;
            btn_prev   <= 1'b0;
            btn_pend   <= 1'b0;
            wr_ptr     <= '0;
            tx_drop    <= 1'b0;
        end else begin
            btn_prev <= btn;
            tx_drop  <= (acc_valid && !acc_fits) || drop_echo;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (seq_active) begin
                if (seq_idx == seq_len - LW'(1)) seq_active <= 1'b0;
                else                             seq_idx    <= seq_idx + LW'(1);
            end else if (admit) begin
                seq_active <= 1'b1;
                seq_len    <= acc_len;
                seq_idx    <= '0;
                for (int i = 0; i < GMAX; i++) seq_buf[i] <= acc_grp[i];
            end
            if (take_echo) echo_pend <= 1'b0;
            if (set_echo) begin
                echo_pend <= 1'b1;
                echo_len  <= rx_len;
                for (int i = 0; i < GMAX; i++) echo_buf[i] <= rx_grp[i];
            end
            if (take_btn)     btn_pend <= 1'b0;
            else if (set_btn) btn_pend <= 1'b1;
        end
    end

    // FIFO storage needs no reset: the pointers define what is valid
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= seq_buf[seq_idx];
    end

    // Transmit FSM: send one byte, then wait for the uart to go busy and idle again
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            bus.tx_send <= 1'b0;
            bus.tx_data <= '0;
            rd_ptr      <= '0;
        end else begin
            bus.tx_send <= 1'b0;
            case (state)
                S_IDLE: if (pop) begin
                    bus.tx_data <= fifo_mem[rd_ptr[AW-1:0]];
                    bus.tx_send <= 1'b1;
                    rd_ptr      <= rd_ptr + PW'(1);
                    state       <= S_WAIT_LO;
                end
                S_WAIT_LO: if (!bus.tx_ready) state <= S_WAIT_HI;
                S_WAIT_HI: if (bus.tx_ready)  state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_uart_text_buffer.sv
// ============================================================================
//  Module      : tb_uart_text_buffer
//  Description : Self-checking bench for uart_text_buffer with a queue-based
//                model of the text buffer and of the expected TX byte stream.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_text_buffer;
    localparam int NC = 60;
    localparam int CW = $clog2(NC + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             btn = 1'b0;
    logic [7:0]       sw = 8'h00;
    logic [NC*8-1:0]  characters;
    logic [CW-1:0]    char_count;
    logic             overflow;
    logic             tx_drop;

    logic             hold = 1'b0;
    logic             no_ack = 1'b0;
    int               busy_cnt = 0;
    int               drop_cnt = 0;
    int               n_pass = 0;
    int               n_total = 0;

    logic [7:0]       cap_q[$];
    logic [7:0]       exp_q[$];
    logic [7:0]       mq[$];
    logic             m_ovf = 1'b0;

    uart_text_buffer_if #(.CHAR_WIDTH(8)) bus ();

    uart_text_buffer #(
        .NUM_CHARS(NC), .CHAR_WIDTH(8), .SW_WIDTH(8), .TX_DEPTH(8), .ECHO_EN(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .btn(btn), .sw(sw),
        .characters(characters), .char_count(char_count),
        .overflow(overflow), .tx_drop(tx_drop)
    );

    always #5 clk = ~clk;

    assign bus.tx_ready = !hold && (busy_cnt == 0);

    // uart transmitter model: captures each request and stays busy a few cycles
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) busy_cnt = 0;
            else begin
                if (busy_cnt != 0) busy_cnt--;
                if (bus.tx_send === 1'b1) begin
                    cap_q.push_back(bus.tx_data);
                    if (!no_ack) busy_cnt = 4;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (tx_drop === 1'b1) drop_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    task automatic model_rx(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            if (mq.size() == NC) begin
                void'(mq.pop_front());
                m_ovf = 1'b1;
            end
            mq.push_back(b);
            exp_q.push_back(b);
        end else if (b == 8'h08 || b == 8'h7F) begin
            if (mq.size() > 0) begin
                void'(mq.pop_back());
                exp_q.push_back(8'h08); exp_q.push_back(8'h20); exp_q.push_back(8'h08);
            end
        end else if (b == 8'h0D) begin
            mq.delete();
            exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        end
    endtask

    task automatic model_btn(input logic [7:0] v);
        string hx = "0123456789ABCDEF";
        exp_q.push_back(hx[v[7:4]]);
        exp_q.push_back(hx[v[3:0]]);
    endtask

    function automatic logic [NC*8-1:0] model_vec();
        logic [NC*8-1:0] v = '0;
        for (int i = 0; i < mq.size(); i++) v[i*8 +: 8] = mq[mq.size()-1-i];
        return v;
    endfunction

    function automatic string q2s(input logic [7:0] q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
        return s;
    endfunction

    // ---------------- stimulus tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
        btn = 1'b0; hold = 1'b0; no_ack = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        mq.delete(); exp_q.delete(); cap_q.delete(); m_ovf = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] b, input int gap);
        @(negedge clk);
        bus.rx_valid = 1'b1; bus.rx_data = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        model_rx(b);
        repeat (gap) @(negedge clk);
    endtask

    task automatic press_btn(input logic [7:0] v);
        @(negedge clk);
        sw = v; btn = 1'b1;
        repeat (3) @(negedge clk);
        btn = 1'b0;
        @(negedge clk);
        model_btn(v);
    endtask

    task automatic wait_drain(output bit timed_out);
        int n = 0;
        while (cap_q.size() < exp_q.size() && n < 1000) begin
            @(negedge clk);
            n++;
        end
        timed_out = (cap_q.size() < exp_q.size());
        repeat (20) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        send_rx(8'h58, 2);
        #2 reset = 1'b0;
        #1;
        n_total++;
        if ({characters, char_count, overflow, bus.tx_send, bus.tx_data, tx_drop} !== '0)
            $display("FAIL reset_state: chars=%h count=%0d ovf=%b send=%b data=%h drop=%b, want all 0",
                     characters, char_count, overflow, bus.tx_send, bus.tx_data, tx_drop);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_hi();
        bit to;
        do_reset();
        send_rx(8'h48, 8);
        send_rx(8'h49, 8);
        wait_drain(to);
        n_total++;
        if (characters[15:0] !== 16'h4849 || char_count !== CW'(2))
            $display("FAIL hi_chars: got %h/%0d want 4849/2", characters[15:0], char_count);
        else n_pass++;
        n_total++;
        if (to || q2s(cap_q) != "48 49 ")
            $display("FAIL hi_tx: got %s want 48 49", q2s(cap_q));
        else n_pass++;
    endtask

    task automatic test_backspace();
        bit to;
        do_reset();
        send_rx(8'h41, 8);
        send_rx(8'h08, 8);
        wait_drain(to);
        n_total++;
        if (characters !== '0 || char_count !== '0)
            $display("FAIL bs_chars: got %h/%0d want 0/0", characters[15:0], char_count);
        else n_pass++;
        n_total++;
        if (to || q2s(cap_q) != "41 08 20 08 ")
            $display("FAIL bs_tx: got %s want 41 08 20 08", q2s(cap_q));
        else n_pass++;
        send_rx(8'h08, 8);
        wait_drain(to);
        n_total++;
        if (to || char_count !== '0 || q2s(cap_q) != "41 08 20 08 ")
            $display("FAIL bs_empty: got count %0d tx %s want 0 and no new tx", char_count, q2s(cap_q));
        else n_pass++;
    endtask

    task automatic test_overflow();
        bit to;
        logic [7:0] b;
        do_reset();
        for (int i = 0; i < NC + 1; i++) begin
            b = 8'h21 + 8'(i);
            send_rx(b, 8);
        end
        n_total++;
        if (char_count !== CW'(NC) || overflow !== 1'b1 || characters !== model_vec())
            $display("FAIL ovf_full: got count %0d ovf %b top %h want %0d 1 %h",
                     char_count, overflow, characters[NC*8-1 -: 8], NC, mq[0]);
        else n_pass++;
        send_rx(8'h0D, 8);
        wait_drain(to);
        n_total++;
        if (characters !== '0 || char_count !== '0 || overflow !== 1'b1)
            $display("FAIL ovf_cr: got count %0d ovf %b want 0 sticky 1", char_count, overflow);
        else n_pass++;
        n_total++;
        if (to || q2s(cap_q) != q2s(exp_q))
            $display("FAIL ovf_tx: got %s want %s", q2s(cap_q), q2s(exp_q));
        else n_pass++;
    endtask

    task automatic test_button();
        bit to;
        do_reset();
        @(negedge clk);
        sw = 8'h3C; btn = 1'b1;
        repeat (40) @(negedge clk);
        btn = 1'b0;
        model_btn(8'h3C);
        wait_drain(to);
        n_total++;
        if (to || q2s(cap_q) != "33 43 ")
            $display("FAIL btn_hex: got %s want 33 43", q2s(cap_q));
        else n_pass++;
    endtask

    task automatic test_fifo_full();
        bit to;
        int d0;
        do_reset();
        hold = 1'b1;
        for (int i = 0; i < 8; i++) send_rx(8'h61 + 8'(i), 3);
        d0 = drop_cnt;
        @(negedge clk);
        sw = 8'hA5; btn = 1'b1;
        repeat (10) @(negedge clk);
        btn = 1'b0;
        n_total++;
        if (drop_cnt - d0 !== 1)
            $display("FAIL full_drop: got %0d drop pulses want 1", drop_cnt - d0);
        else n_pass++;
        hold = 1'b0;
        wait_drain(to);
        n_total++;
        if (to || q2s(cap_q) != q2s(exp_q))
            $display("FAIL full_tx: got %s want %s", q2s(cap_q), q2s(exp_q));
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit to;
        do_reset();
        @(negedge clk);
        bus.rx_valid = 1'b1; bus.rx_data = 8'h5A; sw = 8'h7E; btn = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        model_rx(8'h5A);
        model_btn(8'h7E);
        repeat (3) @(negedge clk);
        btn = 1'b0;
        wait_drain(to);
        n_total++;
        if (to || q2s(cap_q) != "5a 37 45 ")
            $display("FAIL rx_btn_order: got %s want 5a 37 45", q2s(cap_q));
        else n_pass++;
    endtask

    task automatic test_reset_wait_lo();
        int n = 0;
        do_reset();
        no_ack = 1'b1;
        send_rx(8'h51, 0);
        while (cap_q.size() == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (cap_q.size() != 1) $display("FAIL wlo_send: got %0d sends want 1", cap_q.size());
        else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_total++;
        if ({characters, char_count, overflow, bus.tx_send, bus.tx_data, tx_drop} !== '0)
            $display("FAIL wlo_reset: send=%b data=%h count=%0d want all 0",
                     bus.tx_send, bus.tx_data, char_count);
        else n_pass++;
        @(negedge clk);
        no_ack = 1'b0;
        reset = 1'b1;
        repeat (30) @(negedge clk);
        n_total++;
        if (cap_q.size() != 1 || bus.tx_send !== 1'b0)
            $display("FAIL wlo_after: got %0d sends want 1", cap_q.size());
        else n_pass++;
    endtask

    task automatic test_random();
        bit to;
        int sel, d0;
        logic [7:0] b;
        do_reset();
        d0 = drop_cnt;
        for (int it = 0; it < 40; it++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 55)      b = 8'($urandom_range(32, 126));
            else if (sel < 70) b = (sel[0]) ? 8'h08 : 8'h7F;
            else if (sel < 76) b = 8'h0D;
            else if (sel < 86) b = (sel[0]) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(128, 255));
            else               b = 8'h00;
            if (sel >= 86) press_btn(8'($urandom_range(0, 255)));
            else           send_rx(b, 2);
            wait_drain(to);
            n_total++;
            if (characters !== model_vec() || char_count !== CW'(mq.size()) || overflow !== m_ovf)
                $display("FAIL rand_state[%0d]: got count %0d ovf %b low %h want %0d %b %h",
                         it, char_count, overflow, characters[31:0], mq.size(), m_ovf, model_vec() >> 0);
            else n_pass++;
            n_total++;
            if (to || q2s(cap_q) != q2s(exp_q))
                $display("FAIL rand_tx[%0d]: got %s want %s", it, q2s(cap_q), q2s(exp_q));
            else n_pass++;
            cap_q.delete();
            exp_q.delete();
        end
        n_total++;
        if (drop_cnt != d0) $display("FAIL rand_drop: got %0d drops want 0", drop_cnt - d0);
        else n_pass++;
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        #3 reset = 1'b0;
        test_reset();
        test_hi();
        test_backspace();
        test_overflow();
        test_button();
        test_fifo_full();
        test_back_to_back();
        test_reset_wait_lo();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

`default_nettype wire
